// File: rtl/neuron_mac_if.sv
// rtl/neuron_mac_if.sv - start, operand and result signals of the neuron multiply-accumulate stage
interface neuron_mac_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] bias;
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] O;
    logic             n_en;
    logic             busy;

    modport master (
        output en, bias, in_valid, x, w,
        input  O, n_en, busy
    );

    modport slave (
        input  en, bias, in_valid, x, w,
        output O, n_en, busy
    );
endinterface

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - serial Q8.24 multiply-accumulate plus bias; NEURON_MAC_SAT_EN selects saturating output
module neuron_mac #(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8,
    parameter int N_INPUTS   = 16
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);
    localparam int W     = INT_SIZE + FLOAT_SIZE;
    localparam int ACC_W = 64;
    localparam logic [8:0] LAST = 9'(N_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    state_t state, state_next;

    logic [8:0]              cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [W-1:0]     bias_r;
    logic [W-1:0]            o_r;
    logic                    n_en_r;
    logic                    busy_r;
    logic                    pair_take;

    logic signed [2*W-1:0]   product;
    logic signed [2*W-1:0]   shifted;
    logic signed [ACC_W-1:0] prod;
    logic [W-1:0]            fit_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pair_take  = 1'b0;
        unique case (state)
            IDLE: if (bus.en) state_next = ACC;
            ACC: begin
                if (bus.in_valid) begin
                    pair_take = 1'b1;
                    if (cnt == LAST) state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arithmetic shift floors toward minus infinity, dropping the extra fraction bits.
    always_comb begin
        product = $signed(bus.x) * $signed(bus.w);
        shifted = product >>> FLOAT_SIZE;
        prod    = ACC_W'(shifted);
    end

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    logic signed [ACC_W-1:0] sum;

    always_comb begin
        sum = acc + ACC_W'(bias_r);
        if (sum > SAT_MAX)      fit_val = {1'b0, {(W-1){1'b1}}};
        else if (sum < SAT_MIN) fit_val = {1'b1, {(W-1){1'b0}}};
        else                    fit_val = sum[W-1:0];
    end
`else
    // Wrapping only needs the low word, so the add is done at output width.
    always_comb begin
        fit_val = W'(acc) + bias_r;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            bias_r <= '0;
            o_r    <= '0;
            n_en_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            n_en_r <= 1'b0;
            busy_r <= (state_next != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.en) begin
                        acc    <= '0;
                        cnt    <= '0;
                        bias_r <= $signed(bus.bias);
                    end
                end
                ACC: begin
                    if (pair_take) begin
                        acc <= acc + prod;
                        cnt <= cnt + 9'd1;
                    end
                end
                FIN: begin
                    o_r    <= fit_val;
                    n_en_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.O    = o_r;
    assign bus.n_en = n_en_r;
    assign bus.busy = busy_r;
endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - randomized self-checking bench for neuron_mac with N_INPUTS=4
module tb_neuron_mac;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_mac_if #(.WIDTH(32)) bus ();

    neuron_mac #(.FLOAT_SIZE(24), .INT_SIZE(8), .N_INPUTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] vx [4];
    logic [31:0] vw [4];
    int   nen_total = 0;
    bit   nen_long  = 0;
    logic nen_prev  = 1'b0;

    always @(negedge clk) begin
        if (bus.n_en === 1'b1) nen_total++;
        if (bus.n_en === 1'b1 && nen_prev === 1'b1) nen_long = 1;
        nen_prev = bus.n_en;
    end

    function automatic longint floor_div(longint a, longint d);
        longint q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [31:0] model(logic [31:0] b);
        longint s = longint'($signed(b));
        for (int k = 0; k < 4; k++)
            s += floor_div(longint'($signed(vx[k])) * longint'($signed(vw[k])), 64'sd16777216);
`ifdef NEURON_MAC_SAT_EN
        if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    function automatic void set_basic();
        vx[0] = 32'h01000000; vw[0] = 32'h00800000;
        vx[1] = 32'h02000000; vw[1] = 32'h00800000;
        vx[2] = 32'hFF800000; vw[2] = 32'h02000000;
        vx[3] = 32'h00400000; vw[3] = 32'h04000000;
    endfunction

    // Drives one neuron starting at a negedge; returns at the negedge where n_en is seen.
    task automatic feed(input logic [31:0] b, input int max_gap, input int en_after,
                        input int rst_after, output logic [31:0] o, output int delay,
                        output logic busy_start, output logic busy_fin);
        delay    = -1;
        o        = 'x;
        busy_fin = 1'bx;
        bus.en = 1'b1; bus.bias = b;
        bus.in_valid = 1'b1; bus.x = $urandom; bus.w = $urandom;
        @(negedge clk);
        bus.en = 1'b0; bus.in_valid = 1'b0;
        busy_start = bus.busy;
        for (int k = 0; k < 4; k++) begin
            if (k == rst_after) begin
                rst = 1'b1;
                #1;
                o = bus.O;
                busy_fin = bus.busy;
                @(negedge clk);
                rst = 1'b0;
                repeat (8) @(negedge clk);
                return;
            end
            if (k == en_after) begin
                bus.en = 1'b1; bus.bias = 32'h7F000000;
                @(negedge clk);
                bus.en = 1'b0;
            end
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            bus.in_valid = 1'b1; bus.x = vx[k]; bus.w = vw[k];
            @(negedge clk);
            bus.in_valid = 1'b0; bus.x = $urandom; bus.w = $urandom;
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.n_en === 1'b1) begin
                delay    = i;
                o        = bus.O;
                busy_fin = bus.busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b0; bus.in_valid = 1'b0;
        bus.x = '0; bus.w = '0; bus.bias = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.O !== 32'h0)  begin failures++; $display("FAIL reset_O got=%h exp=00000000", bus.O); end
        checks++; if (bus.n_en !== 1'b0) begin failures++; $display("FAIL reset_n_en got=%b exp=0", bus.n_en); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_ignores_valid busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_basic();
        logic [31:0] o; int d; logic bs, bf; int n0;
        set_basic();
        n0 = nen_total;
        feed(32'h00200000, 0, -1, -1, o, d, bs, bf);
        checks++; if (o !== 32'h01A00000) begin failures++; $display("FAIL basic_O got=%h exp=01a00000", o); end
        checks++; if (d !== 1)  begin failures++; $display("FAIL basic_latency got=%0d exp=1", d); end
        checks++; if (bs !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", bs); end
        checks++; if (bf !== 1'b0) begin failures++; $display("FAIL basic_busy_fin got=%b exp=0", bf); end
        repeat (3) @(negedge clk);
        checks++; if (bus.O !== 32'h01A00000) begin failures++; $display("FAIL basic_O_hold got=%h exp=01a00000", bus.O); end
        checks++; if (nen_total - n0 !== 1) begin failures++; $display("FAIL basic_nen_count got=%0d exp=1", nen_total - n0); end
    endtask

    task automatic test_gapped();
        logic [31:0] o; int d; logic bs, bf;
        set_basic();
        for (int r = 0; r < 3; r++) begin
            feed(32'h00200000, 3, -1, -1, o, d, bs, bf);
            checks++; if (o !== 32'h01A00000) begin failures++; $display("FAIL gapped_O got=%h exp=01a00000", o); end
            checks++; if (bf !== 1'b0 || d !== 1) begin failures++; $display("FAIL gapped_fin busy=%b delay=%0d exp busy=0 delay=1", bf, d); end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] o; int d; logic bs, bf; logic [31:0] exp_pos, exp_neg;
`ifdef NEURON_MAC_SAT_EN
        exp_pos = 32'h7FFFFFFF; exp_neg = 32'h80000000;
`else
        exp_pos = 32'h40000000; exp_neg = 32'hC0000000;
`endif
        for (int k = 0; k < 4; k++) begin vx[k] = 32'h64000000; vw[k] = 32'h64000000; end
        feed(32'h0, 1, -1, -1, o, d, bs, bf);
        checks++; if (o !== exp_pos) begin failures++; $display("FAIL overflow_pos got=%h exp=%h", o, exp_pos); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) vx[k] = 32'h9C000000;
        feed(32'h0, 1, -1, -1, o, d, bs, bf);
        checks++; if (o !== exp_neg) begin failures++; $display("FAIL overflow_neg got=%h exp=%h", o, exp_neg); end
        @(negedge clk);
    endtask

    task automatic test_floor();
        logic [31:0] o; int d; logic bs, bf;
        vx[0] = 32'h00000001; vw[0] = 32'h00800000;
        vx[1] = 32'hFFFFFFFF; vw[1] = 32'h00800000;
        vx[2] = 32'h0;        vw[2] = $urandom;
        vx[3] = 32'h0;        vw[3] = $urandom;
        feed(32'h0, 0, -1, -1, o, d, bs, bf);
        checks++; if (o !== 32'hFFFFFFFF) begin failures++; $display("FAIL floor_O got=%h exp=ffffffff", o); end
        @(negedge clk);
    endtask

    task automatic test_en_while_busy();
        logic [31:0] o; int d; logic bs, bf; int n0;
        set_basic();
        n0 = nen_total;
        feed(32'h00200000, 1, 2, -1, o, d, bs, bf);
        checks++; if (o !== 32'h01A00000) begin failures++; $display("FAIL en_busy_O got=%h exp=01a00000", o); end
        @(negedge clk);
        checks++; if (nen_total - n0 !== 1) begin failures++; $display("FAIL en_busy_nen_count got=%0d exp=1", nen_total - n0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] o; int d; logic bs, bf; int n0;
        set_basic();
        n0 = nen_total;
        feed(32'h00200000, 1, -1, 2, o, d, bs, bf);
        checks++; if (o !== 32'h0) begin failures++; $display("FAIL rst_mid_O got=%h exp=00000000", o); end
        checks++; if (bf !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bf); end
        checks++; if (nen_total - n0 !== 0) begin failures++; $display("FAIL rst_mid_nen_count got=%0d exp=0", nen_total - n0); end
        feed(32'h00200000, 0, -1, -1, o, d, bs, bf);
        checks++; if (o !== 32'h01A00000) begin failures++; $display("FAIL rst_mid_rerun got=%h exp=01a00000", o); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] o; int d; logic bs, bf; logic [31:0] b2, exp2;
        set_basic();
        feed(32'h00200000, 0, -1, -1, o, d, bs, bf);
        checks++; if (o !== 32'h01A00000) begin failures++; $display("FAIL b2b_first got=%h exp=01a00000", o); end
        for (int k = 0; k < 4; k++) begin vx[k] = $urandom_range(32'h04000000, 0) - 32'h02000000; vw[k] = $urandom; end
        b2 = $urandom;
        exp2 = model(b2);
        feed(b2, 0, -1, -1, o, d, bs, bf);
        checks++; if (bs !== 1'b1) begin failures++; $display("FAIL b2b_start busy got=%b exp=1", bs); end
        checks++; if (o !== exp2 || d !== 1) begin failures++; $display("FAIL b2b_second got=%h delay=%0d exp=%h delay=1", o, d, exp2); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] o; int d; logic bs, bf; logic [31:0] b, e;
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (r % 2 == 0) begin
                    vx[k] = $urandom_range(32'h10000000, 0) - 32'h08000000;
                    vw[k] = $urandom_range(32'h10000000, 0) - 32'h08000000;
                end else begin
                    vx[k] = $urandom; vw[k] = $urandom;
                end
            end
            b = $urandom;
            e = model(b);
            feed(b, 2, -1, -1, o, d, bs, bf);
            checks++; if (o !== e || d !== 1) begin failures++; $display("FAIL random_%0d got=%h delay=%0d exp=%h delay=1", r, o, d, e); end
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);
        checks++; if (nen_long !== 1'b0) begin failures++; $display("FAIL n_en_width got=multi-cycle exp=single"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_floor();
        test_en_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
